// File: rtl/sum_disp_pkg.sv
// sum_disp_pkg: shared state types, widths and 7-segment encoding for the sum display path
package sum_disp_pkg;
  typedef enum logic {IDLE, CONV} conv_state_t;
  typedef enum logic [1:0] {BLANK, TENS, UNITS} disp_state_t;
  localparam int BCD_W = 4;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  function automatic logic [6:0] seg_enc(input logic [BCD_W-1:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/bin2bcd_serial.sv
// bin2bcd_serial: MSB-first double-dabble, one shift per cycle, result presented with done
module bin2bcd_serial
  import sum_disp_pkg::*;
#(
  parameter int SUM_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SUM_W-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] units
);
  localparam int CW = $clog2(SUM_W + 1);
  localparam int SW = 2 * BCD_W + SUM_W;
  logic [SUM_W-1:0] bin_q;
  logic [BCD_W-1:0] t_q, u_q, t_adj, u_adj;
  logic [CW-1:0] cnt;
  logic [SW-1:0] sh;
  assign t_adj = t_q >= 4'd5 ? t_q + 4'd3 : t_q;
  assign u_adj = u_q >= 4'd5 ? u_q + 4'd3 : u_q;
  assign sh = {t_adj, u_adj, bin_q} << 1;
  assign tens = sh[SW-1 -: BCD_W];
  assign units = sh[SW-BCD_W-1 -: BCD_W];
  assign done = busy && cnt == CW'(1);
  // Load on start, then adjust-and-shift once per cycle until cnt runs out
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt <= '0;
      bin_q <= '0;
      t_q <= '0;
      u_q <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt <= CW'(SUM_W);
      bin_q <= bin_in;
      t_q <= '0;
      u_q <= '0;
    end else if (busy) begin
      busy <= cnt != CW'(1);
      cnt <= cnt - CW'(1);
      bin_q <= sh[SUM_W-1:0];
      t_q <= tens;
      u_q <= units;
    end
  end
endmodule

// File: rtl/sum_display_sequencer.sv
// sum_display_sequencer: converts an accepted binary sum to BCD and multiplexes tens/units onto one 7-segment digit
module sum_display_sequencer
  import sum_disp_pkg::*;
#(
  parameter int SUM_W = 5,
  parameter int DWELL_CYCLES = 1000000,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SUM_W-1:0] sum_in,
  input  logic             sum_valid,
  output logic             sum_ready,
  output logic [6:0]       seg,
  output logic             dp
);
  localparam int DW = DWELL_CYCLES > 1 ? $clog2(DWELL_CYCLES) : 1;
  localparam logic INV = SEG_ACTIVE_LOW != 0;
  conv_state_t cst;
  disp_state_t dst;
  logic start, busy, done, dwell_end;
  logic [BCD_W-1:0] tens, units, tens_q, units_q;
  logic [DW-1:0] dwell;
  logic [6:0] seg_nx;
  assign start = sum_valid && sum_ready && !busy;
  assign dwell_end = dwell == DW'(DWELL_CYCLES - 1);
  assign seg_nx = dst == TENS ? seg_enc(tens_q) : dst == UNITS ? seg_enc(units_q) : SEG_BLANK;
  bin2bcd_serial #(.SUM_W(SUM_W)) u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin_in(sum_in),
    .busy  (busy),
    .done  (done),
    .tens  (tens),
    .units (units)
  );
  // Converter handshake: ready only while idle, dropped for the whole conversion
  always_ff @(posedge clk) begin
    if (rst) begin
      cst <= IDLE;
      sum_ready <= 1'b1;
    end else if (cst == IDLE && start) begin
      cst <= CONV;
      sum_ready <= 1'b0;
    end else if (cst == CONV && done) begin
      cst <= IDLE;
      sum_ready <= 1'b1;
    end
  end
  // Display sequencing: a digit load restarts the cycle, otherwise alternate when tens is non-zero
  always_ff @(posedge clk) begin
    if (rst) begin
      dst <= BLANK;
      tens_q <= '0;
      units_q <= '0;
      dwell <= '0;
    end else if (done) begin
      dst <= tens != '0 ? TENS : UNITS;
      tens_q <= tens;
      units_q <= units;
      dwell <= '0;
    end else if (dst == TENS || (dst == UNITS && tens_q != '0)) begin
      dst <= dwell_end ? (dst == TENS ? UNITS : TENS) : dst;
      dwell <= dwell_end ? '0 : dwell + DW'(1);
    end
  end
  // Output register, optionally inverted for common-anode displays
  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= {7{INV}};
      dp <= INV;
    end else begin
      seg <= seg_nx ^ {7{INV}};
      dp <= (dst == TENS) ^ INV;
    end
  end
endmodule

// File: tb/tb_sum_display_sequencer.sv
// tb_sum_display_sequencer: directed checks of handshake, BCD conversion and digit alternation
module tb_sum_display_sequencer;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] sum_in;
  logic sum_valid;
  logic sum_ready, sum_ready_n;
  logic [6:0] seg, seg_n;
  logic dp, dp_n;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  sum_display_sequencer #(.SUM_W(5), .DWELL_CYCLES(4), .SEG_ACTIVE_LOW(0)) dut (
    .clk(clk), .rst(rst), .sum_in(sum_in), .sum_valid(sum_valid),
    .sum_ready(sum_ready), .seg(seg), .dp(dp)
  );
  sum_display_sequencer #(.SUM_W(5), .DWELL_CYCLES(4), .SEG_ACTIVE_LOW(1)) dut_n (
    .clk(clk), .rst(rst), .sum_in(sum_in), .sum_valid(sum_valid),
    .sum_ready(sum_ready_n), .seg(seg_n), .dp(dp_n)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_out(input string tag, input logic [6:0] s, input logic d);
    checks += 4;
    assert (seg === s) else begin errors++; $error("FAIL %s seg=%h exp=%h", tag, seg, s); end
    assert (dp === d) else begin errors++; $error("FAIL %s dp=%b exp=%b", tag, dp, d); end
    assert (seg_n === ~s) else begin errors++; $error("FAIL %s_inv seg=%h exp=%h", tag, seg_n, ~s); end
    assert (dp_n === ~d) else begin errors++; $error("FAIL %s_inv dp=%b exp=%b", tag, dp_n, ~d); end
  endtask
  task automatic chk_rdy(input string tag, input logic r);
    checks += 2;
    assert (sum_ready === r) else begin errors++; $error("FAIL %s ready=%b exp=%b", tag, sum_ready, r); end
    assert (sum_ready_n === r) else begin errors++; $error("FAIL %s_inv ready=%b exp=%b", tag, sum_ready_n, r); end
  endtask
  task automatic convert(input logic [4:0] v);
    sum_in = v;
    sum_valid = 1'b1;
    step();
    sum_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_rdy("conv_busy", 1'b0);
      step();
    end
    chk_rdy("conv_done", 1'b1);
    step();
  endtask
  initial begin
    rst = 1'b1;
    sum_valid = 1'b1;
    sum_in = 5'd7;
    repeat (3) step();
    chk_out("rst_hold", 7'h00, 1'b0);
    chk_rdy("rst_hold", 1'b1);
    rst = 1'b0;
    sum_valid = 1'b0;
    step();
    chk_out("rst_rel", 7'h00, 1'b0);
    chk_rdy("rst_rel", 1'b1);
    step();
    chk_out("rst_idle", 7'h00, 1'b0);
    convert(5'd7);
    for (int i = 0; i < 20; i++) begin
      chk_out("sum7", 7'h07, 1'b0);
      step();
    end
    convert(5'd30);
    for (int i = 0; i < 24; i++) begin
      chk_out("sum30", ((i / 4) % 2 == 0) ? 7'h4F : 7'h3F, ((i / 4) % 2 == 0));
      step();
    end
    sum_in = 5'd12;
    sum_valid = 1'b1;
    step();
    sum_in = 5'd25;
    for (int i = 0; i < 5; i++) begin
      chk_rdy("sum12_busy", 1'b0);
      step();
    end
    chk_rdy("sum12_done", 1'b1);
    step();
    sum_valid = 1'b0;
    chk_rdy("sum25_acc", 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk_out("sum12_t", 7'h06, 1'b1);
      step();
    end
    chk_out("sum12_u", 7'h5B, 1'b0);
    step();
    chk_out("sum12_u", 7'h5B, 1'b0);
    chk_rdy("sum25_done", 1'b1);
    step();
    for (int i = 0; i < 4; i++) begin
      chk_out("sum25_t", 7'h5B, 1'b1);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      chk_out("sum25_u", 7'h6D, 1'b0);
      step();
    end
    chk_out("sum25_t2", 7'h5B, 1'b1);
    sum_in = 5'd31;
    sum_valid = 1'b1;
    step();
    sum_valid = 1'b0;
    chk_rdy("sum31_busy", 1'b0);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_out("abort", 7'h00, 1'b0);
    chk_rdy("abort", 1'b1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk_out("abort_blank", 7'h00, 1'b0);
      chk_rdy("abort_idle", 1'b1);
    end
    convert(5'd10);
    for (int i = 0; i < 4; i++) begin
      chk_out("sum10_t", 7'h06, 1'b1);
      step();
    end
    chk_out("sum10_u", 7'h3F, 1'b0);
    sum_in = 5'd0;
    sum_valid = 1'b1;
    step();
    sum_valid = 1'b0;
    chk_rdy("sum0_busy", 1'b0);
    chk_out("sum10_u", 7'h3F, 1'b0);
    step();
    chk_out("sum10_u", 7'h3F, 1'b0);
    step();
    chk_out("sum10_u", 7'h3F, 1'b0);
    step();
    chk_out("sum10_t2", 7'h06, 1'b1);
    step();
    chk_out("sum10_t2", 7'h06, 1'b1);
    step();
    chk_out("sum10_t2", 7'h06, 1'b1);
    chk_rdy("sum0_done", 1'b1);
    for (int i = 0; i < 12; i++) begin
      step();
      chk_out("sum0", 7'h3F, 1'b0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
